// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// rsa_pkg : shared widths and controller state encoding for the RSA datapath
// Revision: 1.0
// ============================================================================
package rsa_pkg;

  localparam int RSA_WIDTH   = 1024;
  localparam int RSA_EBITS_W = 11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SQR_GO   = 3'd2,
    S_SQR_WAIT = 3'd3,
    S_MUL_GO   = 3'd4,
    S_MUL_WAIT = 3'd5,
    S_NEXT     = 3'd6,
    S_FINISH   = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cond_sub.sv
`default_nettype none
// ============================================================================
// cond_sub : final compare-and-subtract of an unreduced Montgomery product
// Revision: 1.0
// ============================================================================
module cond_sub
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r
);

  logic ge;

  assign ge = (p >= {1'b0, m});
  assign r  = ge ? (p[WIDTH-1:0] - m) : p[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// mod_exp_ctrl : left-to-right square-and-multiply sequencer driving an
//                external Montgomery product stage.
//                Option macro: MOD_EXP_SKIP_LEADING_ZEROS_EN
// Revision: 1.0
// ============================================================================
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH   = RSA_WIDTH,
  parameter int EBITS_W = RSA_EBITS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   base_m,
  input  logic [WIDTH-1:0]   one_m,
  input  logic [WIDTH-1:0]   modulus,
  input  logic [WIDTH-1:0]   exp,
  input  logic [EBITS_W-1:0] exp_bits,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result_m,
  output logic               mp_start,
  output logic [WIDTH-1:0]   mp_a,
  output logic [WIDTH-1:0]   mp_b,
  output logic [WIDTH-1:0]   mp_m,
  input  logic               mp_stop,
  input  logic [WIDTH:0]     mp_p
);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   acc, acc_d, base_r, mod_r, exp_r, red;
  logic [EBITS_W-1:0] idx, eff_bits;
  logic               wait_first, capture, cur_bit;

  cond_sub #(.WIDTH(WIDTH)) u_cond_sub (
    .p (mp_p),
    .m (mod_r),
    .r (red)
  );

  assign busy     = (state != S_IDLE);
  assign mp_start = (state == S_SQR_GO) || (state == S_MUL_GO);
  assign mp_m     = mod_r;
  assign cur_bit  = |(exp_r & (WIDTH'(1) << idx));
  assign capture  = ((state == S_SQR_WAIT) || (state == S_MUL_WAIT)) &&
                    !wait_first && mp_stop;

  // Number of exponent bits actually walked, counted from bit 0 upward.
  always_comb begin
    eff_bits = exp_bits;
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
    eff_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (exp[i] && (i < int'(exp_bits))) eff_bits = EBITS_W'(i + 1);
    end
`endif
  end

  always_comb begin
    state_nx = state;
    acc_d    = acc;
    case (state)
      S_IDLE:     if (start) state_nx = S_LOAD;
      S_LOAD: begin
        acc_d    = one_m;
        state_nx = (eff_bits == '0) ? S_FINISH : S_SQR_GO;
      end
      S_SQR_GO:   state_nx = S_SQR_WAIT;
      S_SQR_WAIT: if (capture) begin
        acc_d    = red;
        state_nx = cur_bit ? S_MUL_GO : S_NEXT;
      end
      S_MUL_GO:   state_nx = S_MUL_WAIT;
      S_MUL_WAIT: if (capture) begin
        acc_d    = red;
        state_nx = S_NEXT;
      end
      S_NEXT:     state_nx = (idx == '0) ? S_FINISH : S_SQR_GO;
      S_FINISH:   state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      base_r     <= '0;
      mod_r      <= '0;
      exp_r      <= '0;
      idx        <= '0;
      wait_first <= 1'b0;
      mp_a       <= '0;
      mp_b       <= '0;
      result_m   <= '0;
      done       <= 1'b0;
    end else begin
      acc        <= acc_d;
      wait_first <= mp_start;
      done       <= (state == S_FINISH);
      if (state == S_LOAD) begin
        base_r <= base_m;
        mod_r  <= modulus;
        exp_r  <= exp;
        idx    <= eff_bits - EBITS_W'(1);
      end
      if (state == S_NEXT)   idx      <= idx - EBITS_W'(1);
      if (state == S_FINISH) result_m <= acc;
      // Operands are set up one edge ahead so they are valid in the GO cycle.
      if (state_nx == S_SQR_GO) begin
        mp_a <= acc_d;
        mp_b <= acc_d;
      end else if (state_nx == S_MUL_GO) begin
        mp_a <= acc_d;
        mp_b <= base_r;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mod_exp_ctrl : vector table + scoreboard bench for mod_exp_ctrl, WIDTH=8
//                   with a behavioural Montgomery stage (R = 256).
// Revision: 1.0
// ============================================================================
module tb_mod_exp_ctrl;

  localparam int W  = 8;
  localparam int EW = 11;
`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [W-1:0]  base_m = '0, one_m = '0, modulus = '0, exp = '0;
  logic [EW-1:0] exp_bits = '0;
  logic          busy, done, mp_start;
  logic [W-1:0]  result_m, mp_a, mp_b, mp_m;
  logic          mp_stop = 1'b0;
  logic [W:0]    mp_p = '0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.WIDTH(W), .EBITS_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_m(base_m), .one_m(one_m), .modulus(modulus),
    .exp(exp), .exp_bits(exp_bits),
    .busy(busy), .done(done), .result_m(result_m),
    .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b), .mp_m(mp_m),
    .mp_stop(mp_stop), .mp_p(mp_p)
  );

  typedef struct {
    int base; int one; int m; int e; int bits;
    int res; int p_full; int p_skip; int lat;
  } vec_t;
  typedef struct { int res; int pulses; int lat; } exp_t;

  vec_t tbl[7];
  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, pulses = 0, done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mp_start) pulses++;
    if (done) done_cnt++;
  end

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int rinv(int m);
    for (int r = 1; r < m; r++) if (((256 * r) % m) == 1) return r;
    return 0;
  endfunction

  function automatic int mpm(int a, int b, int m);
    if (m == 0) return 0;
    return ((a * b) % m) * rinv(m) % m;
  endfunction

  function automatic void sw_exp(input int base, input int one, input int m,
                                 input int e, input int bits,
                                 output int res, output int pf, output int ps);
    int acc, msb;
    acc = one; msb = 0; pf = 0; ps = 0;
    for (int i = 0; i < bits; i++) if (e[i]) msb = i + 1;
    for (int i = bits - 1; i >= 0; i--) begin
      acc = mpm(acc, acc, m);
      pf++; if (i < msb) ps++;
      if (e[i]) begin
        acc = mpm(acc, base, m);
        pf++; if (i < msb) ps++;
      end
    end
    res = acc;
  endfunction

  // Montgomery stage: a bogus early stop in the first wait cycle, then the
  // real product after a random delay, sometimes left unreduced (+M).
  initial begin
    int p, a0, b0, m0, d, n;
    n = 0;
    @(negedge clk);
    forever begin
      if (mp_start) begin
        a0 = int'(mp_a); b0 = int'(mp_b); m0 = int'(mp_m);
        p = mpm(a0, b0, m0);
        if ((n % 2) == 1) p += m0;
        n++;
        @(negedge clk); mp_stop = 1'b1; mp_p = '1;
        @(negedge clk); mp_stop = 1'b0;
        d = $urandom_range(0, 2);
        repeat (d) @(negedge clk);
        mp_stop = 1'b1; mp_p = 9'(p);
        if (busy)
          check("mp_operands_stable",
                int'(mp_a == 8'(a0) && mp_b == 8'(b0) && mp_m == 8'(m0)), 1);
        @(negedge clk); mp_stop = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic wait_done(int t0);
    exp_t x;
    int   k;
    k = 0;
    while (!done && k < 3000) begin @(negedge clk); k++; end
    if (!done) begin
      check("done_timeout", 0, 1);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else if (sbq.size() == 0) begin
      check("unexpected_done", 1, 0);
    end else begin
      x = sbq.pop_front();
      check("result_m", int'(result_m), x.res);
      check("mp_start_pulses", pulses, x.pulses);
      if (x.lat >= 0) check("done_latency", cyc - t0, x.lat);
      check("busy_at_done", int'(busy), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
    end
  endtask

  task automatic drive(vec_t v);
    base_m = 8'(v.base); one_m = 8'(v.one); modulus = 8'(v.m);
    exp = 8'(v.e); exp_bits = EW'(v.bits);
  endtask

  task automatic run(vec_t v);
    exp_t x;
    int   t0;
    @(negedge clk);
    drive(v);
    start = 1'b1; pulses = 0; t0 = cyc;
    x.res = v.res; x.pulses = SKIP ? v.p_skip : v.p_full; x.lat = v.lat;
    sbq.push_back(x);
    @(negedge clk); start = 1'b0;
    wait_done(t0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t x;
    int   t0, k, dc;
    //           base one  m   exp   bits res full skip lat
    tbl[0] = '{5, 9, 13, 5,     3, 2, 5,  5, -1};
    tbl[1] = '{5, 9, 13, 0,     4, 9, 4,  0, -1};
    tbl[2] = '{5, 9, 13, 5,     0, 9, 0,  0,  3};
    tbl[3] = '{5, 9, 13, 5,     8, 2, 10, 5, -1};
    tbl[4] = '{5, 9, 13, 3,     2, 7, 4,  4, -1};
    tbl[5] = '{5, 9, 13, 8'hFF, 4, 7, 8,  8, -1};
    tbl[6] = '{5, 9, 13, 8'h10, 4, 9, 4,  0, -1};

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mp_start", int'(mp_start), 0);
    check("rst_result_m", int'(result_m), 0);
    check("rst_mp_abm", int'(mp_a) + int'(mp_b) + int'(mp_m), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(tbl[i]);

    for (int i = 0; i < 4; i++) begin
      v.m    = 2 * $urandom_range(1, 127) + 1;
      v.one  = 256 % v.m;
      v.base = $urandom_range(0, v.m - 1);
      v.e    = $urandom_range(0, 255);
      v.bits = $urandom_range(0, 8);
      v.lat  = -1;
      sw_exp(v.base, v.one, v.m, v.e, v.bits, v.res, v.p_full, v.p_skip);
      run(v);
    end

    // Second start with different operands mid-run must be ignored.
    @(negedge clk);
    drive(tbl[0]);
    start = 1'b1; pulses = 0; t0 = cyc;
    x.res = 2; x.pulses = 5; x.lat = -1;
    sbq.push_back(x);
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    base_m = 8'd3; modulus = 8'd11; one_m = 8'd3; exp = 8'hFF; exp_bits = EW'(8);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(t0);
    dc = done_cnt;
    repeat (20) @(negedge clk);
    check("no_extra_done", done_cnt, dc);

    // Reset while waiting on the first square.
    @(negedge clk);
    drive(tbl[0]);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!mp_start && k < 50) begin @(negedge clk); k++; end
    check("reach_sqr_go", int'(mp_start), 1);
    @(negedge clk);
    check("busy_in_wait", int'(busy), 1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_mp_start", int'(mp_start), 0);
    check("abort_result_m", int'(result_m), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    run(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1024: operand/modulus width in bits.
REQ-002 SHALL have parameter EBITS_W, default 11: width of the exponent bit-count input.
REQ-003 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start (input, 1): begin exponentiation; sampled only in IDLE.
REQ-005 SHALL have ports base_m, one_m, modulus (input, WIDTH each): base in Montgomery form, R mod M, and odd modulus M.
REQ-006 SHALL have ports exp (input, WIDTH) and exp_bits (input, EBITS_W): exponent and number of its bits to process.
REQ-007 SHALL have port busy (output, 1): high outside IDLE.
REQ-008 SHALL have port done (output, 1): one-cycle pulse when result is valid.
REQ-009 SHALL have port result_m (output, WIDTH): final value in Montgomery form, held until next start.
REQ-010 SHALL have ports mp_start (output, 1), mp_a, mp_b, mp_m (output, WIDTH each): drive the Montgomery product stage.
REQ-011 SHALL have ports mp_stop (input, 1) and mp_p (input, WIDTH+1): completion flag and unreduced product from the Montgomery stage.

Function
REQ-012 SHALL compute left-to-right square-and-multiply: acc = one_m; for i = exp_bits-1 down to 0: acc = MP(acc,acc); if exp[i], acc = MP(acc,base_m).
REQ-013 SHALL implement states IDLE, LOAD, SQR_GO, SQR_WAIT, MUL_GO, MUL_WAIT, NEXT, FINISH.
REQ-014 SHALL latch base_m, one_m, modulus, exp and exp_bits in LOAD; later input changes SHALL NOT affect the run.
REQ-015 SHALL transition IDLE->LOAD on start; LOAD->FINISH if exp_bits==0, else LOAD->SQR_GO.
REQ-016 SHALL in a *_GO state drive mp_start high for exactly one cycle with mp_a/mp_b/mp_m stable from that cycle until capture.
REQ-017 SHALL ignore mp_stop in the first cycle of a *_WAIT state and capture mp_p on the first later cycle with mp_stop==1.
REQ-018 SHALL reduce each captured product: acc = (mp_p >= modulus) ? mp_p - modulus : mp_p, truncated to WIDTH.
REQ-019 SHALL go SQR_WAIT->MUL_GO if the current exp bit is 1, else ->NEXT; MUL_WAIT->NEXT.
REQ-020 SHALL in NEXT decrement the bit index, then go ->FINISH if the processed bit was index 0, else ->SQR_GO.
REQ-021 SHALL in FINISH load result_m with acc, pulse done, and return to IDLE next cycle.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL make done and result_m update in the same cycle.

Reset
REQ-024 SHALL on rst_n low force state IDLE and set busy=0, done=0, mp_start=0, result_m=0, mp_a=mp_b=mp_m=0, acc=0.
REQ-025 SHALL abort any run in progress on reset mid-operation with no done pulse; the next start after reset SHALL begin a fresh run.

Configuration
REQ-026 SHALL, with MOD_EXP_SKIP_LEADING_ZEROS_EN defined, skip exponent bits above the most-significant 1 within exp_bits, issuing no products for them.
REQ-027 SHALL, without MOD_EXP_SKIP_LEADING_ZEROS_EN, process all exp_bits bits; result_m SHALL be identical in both builds.

Structure
REQ-028 SHALL take WIDTH default, the state encoding, and EBITS_W from a shared package rsa_pkg.
REQ-029 SHALL place the compare-and-subtract reduction of REQ-018 in sub-module cond_sub.

Verification (bench uses a behavioural MP model a*b*R^-1 mod M, WIDTH=8, R=256)
REQ-030 SHALL check M=13, one_m=9, base_m=5, exp=5, exp_bits=3 -> result_m=2, exactly 5 mp_start pulses.
REQ-031 SHALL check exp=0, exp_bits=4 -> result_m=9 (one_m).
REQ-032 SHALL check exp_bits=0 -> done pulses 3 cycles after start, result_m=9, no mp_start pulse.
REQ-033 SHALL check exp=5, exp_bits=8: with macro, 5 mp_start pulses; without, 10; result_m=2 in both.
REQ-034 SHALL check rst_n low during SQR_WAIT -> busy=0 and mp_start=0 at once, no done; a following run with exp=5 returns 2.
REQ-035 SHALL check start pulsed again mid-run with different operands -> ignored, result_m=2.
